// File: rtl/trig_pkg.sv
// Shared mcontrol layout, match encodings and FSM states for the trigger controller.
// Optional range compares are enabled with the TRIG_RANGE_MATCH_EN macro.
package trig_pkg;

    localparam int unsigned BIT_LOAD     = 0;
    localparam int unsigned BIT_STORE    = 1;
    localparam int unsigned BIT_EXEC     = 2;
    localparam int unsigned BIT_M        = 6;
    localparam int unsigned BIT_MATCH_LO = 7;
    localparam int unsigned BIT_MATCH_HI = 8;
    localparam int unsigned BIT_CHAIN    = 11;
    localparam int unsigned BIT_ACTION   = 12;
    localparam int unsigned BIT_HIT      = 20;
    localparam int unsigned BIT_DMODE    = 27;
    localparam int unsigned BIT_TYPE_LO  = 28;

    localparam logic [3:0] MCTRL_TYPE = 4'h2;

    localparam logic [1:0] MATCH_EQ = 2'd0;
    localparam logic [1:0] MATCH_GE = 2'd2;
    localparam logic [1:0] MATCH_LT = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } trig_state_e;

    typedef struct packed {
        logic       dmode;
        logic       hit;
        logic       action;
        logic       chain;
        logic [1:0] match;
        logic       m;
        logic       execute;
        logic       store;
        logic       load;
    } mctrl_t;

    // Only action bit 12 is kept; the other action bits and type are dropped.
    function automatic mctrl_t mctrl_from_word(input logic [31:0] w);
        mctrl_t f;
        f.dmode   = w[BIT_DMODE];
        f.hit     = w[BIT_HIT];
        f.action  = w[BIT_ACTION];
        f.chain   = w[BIT_CHAIN];
        f.match   = w[BIT_MATCH_HI:BIT_MATCH_LO];
        f.m       = w[BIT_M];
        f.execute = w[BIT_EXEC];
        f.store   = w[BIT_STORE];
        f.load    = w[BIT_LOAD];
        return f;
    endfunction

endpackage

// File: rtl/trig_match.sv
// Per-trigger address comparator producing execute and data hit flags.
// Range encodings are compiled in only with TRIG_RANGE_MATCH_EN.
module trig_match
    import trig_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  m_i,
    input  logic                  execute_i,
    input  logic                  store_i,
    input  logic                  load_i,
    input  logic [1:0]            match_i,
    input  logic [DATA_WIDTH-1:0] tdata2_i,
    input  logic                  ex_valid_i,
    input  logic [DATA_WIDTH-1:0] ex_pc_i,
    input  logic                  ls_valid_i,
    input  logic                  ls_wr1_rd0_i,
    input  logic [DATA_WIDTH-1:0] ls_addr_i,
    output logic                  exec_hit_o,
    output logic                  data_hit_o
);

    function automatic logic addr_cmp(input logic [1:0] mode,
                                      input logic [DATA_WIDTH-1:0] addr,
                                      input logic [DATA_WIDTH-1:0] ref_val);
        logic r;
        case (mode)
            MATCH_EQ: r = (addr == ref_val);
`ifdef TRIG_RANGE_MATCH_EN
            MATCH_GE: r = (addr >= ref_val);
            MATCH_LT: r = (addr <  ref_val);
`endif
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

    logic data_sel;

    assign data_sel   = ls_valid_i && ((store_i && ls_wr1_rd0_i) || (load_i && !ls_wr1_rd0_i));
    assign exec_hit_o = m_i && execute_i && ex_valid_i && addr_cmp(match_i, ex_pc_i, tdata2_i);
    assign data_hit_o = m_i && data_sel && addr_cmp(match_i, ls_addr_i, tdata2_i);

endmodule

// File: rtl/trigger_ctrl.sv
// Two-trigger mcontrol storage, match priority/chain resolution and request/ack FSM.
// TRIG_RANGE_MATCH_EN enables >= / < compares and makes match[8] readable.
module trigger_ctrl
    import trig_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rstn,
    input  logic                  tselect,
    input  logic                  tdata1_wr,
    input  logic [DATA_WIDTH-1:0] tdata1_wdata,
    output logic [DATA_WIDTH-1:0] mctrl_rd_data,
    input  logic [DATA_WIDTH-1:0] tdata2_t0,
    input  logic [DATA_WIDTH-1:0] tdata2_t1,
    input  logic                  dbg_mode,
    input  logic                  ex_valid,
    input  logic [DATA_WIDTH-1:0] ex_pc,
    input  logic                  ls_valid,
    input  logic                  ls_wr1_rd0,
    input  logic [DATA_WIDTH-1:0] ls_addr,
    output logic                  trig_req,
    output logic                  trig_dbg,
    output logic [DATA_WIDTH-1:0] trig_tval,
    output logic                  trig_id,
    input  logic                  trig_ack
);

    mctrl_t [1:0]          fld_q, fld_d;
    trig_state_e           state_q;
    logic                  chained_q;
    logic [1:0]            exec_raw, data_raw, exec_hit, data_hit;
    logic                  fire, fire_dbg, fire_id, fire_chained;
    logic [DATA_WIDTH-1:0] fire_tval;
    logic                  ack_take, wr_ok;
    logic [1:0]            ack_set;
    mctrl_t                sel_fld;
    logic                  unused_wdata;

    assign unused_wdata = ^tdata1_wdata;

    trig_match #(.DATA_WIDTH(DATA_WIDTH)) u_match_t0 (
        .m_i          (fld_q[0].m),
        .execute_i    (fld_q[0].execute),
        .store_i      (fld_q[0].store),
        .load_i       (fld_q[0].load),
        .match_i      (fld_q[0].match),
        .tdata2_i     (tdata2_t0),
        .ex_valid_i   (ex_valid),
        .ex_pc_i      (ex_pc),
        .ls_valid_i   (ls_valid),
        .ls_wr1_rd0_i (ls_wr1_rd0),
        .ls_addr_i    (ls_addr),
        .exec_hit_o   (exec_raw[0]),
        .data_hit_o   (data_raw[0])
    );

    trig_match #(.DATA_WIDTH(DATA_WIDTH)) u_match_t1 (
        .m_i          (fld_q[1].m),
        .execute_i    (fld_q[1].execute),
        .store_i      (fld_q[1].store),
        .load_i       (fld_q[1].load),
        .match_i      (fld_q[1].match),
        .tdata2_i     (tdata2_t1),
        .ex_valid_i   (ex_valid),
        .ex_pc_i      (ex_pc),
        .ls_valid_i   (ls_valid),
        .ls_wr1_rd0_i (ls_wr1_rd0),
        .ls_addr_i    (ls_addr),
        .exec_hit_o   (exec_raw[1]),
        .data_hit_o   (data_raw[1])
    );

    assign exec_hit = dbg_mode ? 2'b00 : exec_raw;
    assign data_hit = dbg_mode ? 2'b00 : data_raw;

    // A chain makes t0+t1 one trigger: neither fires alone, the pair reports as t1.
    always_comb begin
        fire         = 1'b0;
        fire_dbg     = 1'b0;
        fire_id      = 1'b0;
        fire_chained = 1'b0;
        fire_tval    = '0;
        if (fld_q[0].chain) begin
            if ((exec_hit[0] || data_hit[0]) && (exec_hit[1] || data_hit[1])) begin
                fire         = 1'b1;
                fire_id      = 1'b1;
                fire_dbg     = fld_q[1].action;
                fire_chained = 1'b1;
                fire_tval    = (exec_hit[0] || exec_hit[1]) ? ex_pc : ls_addr;
            end
        end else if (exec_hit[0]) begin
            fire      = 1'b1;
            fire_dbg  = fld_q[0].action;
            fire_tval = ex_pc;
        end else if (exec_hit[1]) begin
            fire      = 1'b1;
            fire_id   = 1'b1;
            fire_dbg  = fld_q[1].action;
            fire_tval = ex_pc;
        end else if (data_hit[0]) begin
            fire      = 1'b1;
            fire_dbg  = fld_q[0].action;
            fire_tval = ls_addr;
        end else if (data_hit[1]) begin
            fire      = 1'b1;
            fire_id   = 1'b1;
            fire_dbg  = fld_q[1].action;
            fire_tval = ls_addr;
        end
    end

    assign ack_take   = (state_q == REQ) && trig_ack;
    assign ack_set[1] = ack_take && trig_id;
    assign ack_set[0] = ack_take && (!trig_id || chained_q);
    assign wr_ok      = tdata1_wr && !(fld_q[tselect].dmode && !dbg_mode);

    always_comb begin
        fld_d = fld_q;
        if (wr_ok) begin
            fld_d[tselect] = mctrl_from_word(tdata1_wdata[31:0]);
        end
        for (int i = 0; i < 2; i++) begin
            if (ack_set[i]) begin
                fld_d[i].hit = 1'b1;
            end
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rstn) begin
            fld_q <= '0;
        end else begin
            fld_q <= fld_d;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rstn) begin
            state_q   <= IDLE;
            chained_q <= 1'b0;
            trig_req  <= 1'b0;
            trig_dbg  <= 1'b0;
            trig_tval <= '0;
            trig_id   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fire) begin
                        state_q   <= REQ;
                        chained_q <= fire_chained;
                        trig_req  <= 1'b1;
                        trig_dbg  <= fire_dbg;
                        trig_tval <= fire_tval;
                        trig_id   <= fire_id;
                    end
                end
                REQ: begin
                    if (trig_ack) begin
                        state_q  <= IDLE;
                        trig_req <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // match[8] is kept internally so unsupported encodings never match, but reads 0.
    always_comb begin
        sel_fld                                    = fld_q[tselect];
        mctrl_rd_data                              = '0;
        mctrl_rd_data[BIT_TYPE_LO+3:BIT_TYPE_LO]   = MCTRL_TYPE;
        mctrl_rd_data[BIT_DMODE]                   = sel_fld.dmode;
        mctrl_rd_data[BIT_HIT]                     = sel_fld.hit;
        mctrl_rd_data[BIT_ACTION]                  = sel_fld.action;
        mctrl_rd_data[BIT_CHAIN]                   = sel_fld.chain;
`ifdef TRIG_RANGE_MATCH_EN
        mctrl_rd_data[BIT_MATCH_HI]                = sel_fld.match[1];
`endif
        mctrl_rd_data[BIT_MATCH_LO]                = sel_fld.match[0];
        mctrl_rd_data[BIT_M]                       = sel_fld.m;
        mctrl_rd_data[BIT_EXEC]                    = sel_fld.execute;
        mctrl_rd_data[BIT_STORE]                   = sel_fld.store;
        mctrl_rd_data[BIT_LOAD]                    = sel_fld.load;
    end

endmodule
